tag_ctrl: RTL and testbench

- Sequences the ASCON-128 finalization phase around the shared 320-bit state datapath, the permutation unit and the 128-bit tag register.
- Operation order:
  1. Pre-permutation key XOR.
  2. Launch p12 and wait for its completion.
  3. Post-permutation key XOR, then load the tag register.
  4. Either stream the tag out in words (encrypt) or compare it against a reference tag (decrypt).
- Sits between the top-level ASCON FSM, which issues the finalize command, and the datapath/tag register.

---
 rtl/ascon_pack.sv | 20 ++
 rtl/tag_ctrl.sv | 114 +++++++++++
 tb/tb_tag_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_pack.sv
// Shared ASCON definitions: finalization FSM states and the widths and round
// counts used by the tag sequencing logic.
package ascon_pack;

    localparam int TAG_W        = 128;
    localparam int ROUNDS_FINAL = 12;
    localparam int WORD_W_DEF   = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        KEY_PRE = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        LOAD    = 3'd4,
        OUT     = 3'd5,
        CHECK   = 3'd6,
        DONE    = 3'd7
    } fin_state_t;

endpackage

// File: rtl/tag_ctrl.sv
// ASCON-128 finalization sequencer: key XORs around a p12 call, tag load,
// then either word-wise tag emission (encrypt) or tag comparison (decrypt).
module tag_ctrl
    import ascon_pack::*;
#(
    parameter int WORD_W    = WORD_W_DEF,    // 32 or 64
    parameter int NB_ROUNDS = ROUNDS_FINAL
) (
    input  logic              clock_i,
    input  logic              resetb_i,
    input  logic              final_start_i,
    input  logic              decrypt_i,
    input  logic              abort_i,
    output logic              xor_key_pre_o,
    output logic              perm_start_o,
    output logic [3:0]        perm_rounds_o,
    input  logic              perm_done_i,
    output logic              xor_key_post_o,
    output logic              en_tag_o,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [TAG_W-1:0]  tag_ref_i,
    output logic [WORD_W-1:0] tag_word_o,
    output logic              tag_valid_o,
    input  logic              tag_ready_i,
    output logic              auth_ok_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int NB_WORDS = TAG_W / WORD_W;
    localparam int CNT_W    = $clog2(NB_WORDS);

    fin_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              decrypt_q;
    logic              auth_ok_q;
    logic              cnt_last;
    logic              transfer;
    logic [WORD_W-1:0] tag_words [NB_WORDS];

    // Word 0 is the most significant slice of the tag.
    for (genvar i = 0; i < NB_WORDS; i++) begin : g_words
        assign tag_words[i] = tag_i[TAG_W-1-i*WORD_W -: WORD_W];
    end

    assign cnt_last = (cnt_q == CNT_W'(NB_WORDS - 1));
    assign transfer = (state_q == OUT) && tag_ready_i;

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // state_d unassigned, which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (final_start_i) state_d = KEY_PRE;
            KEY_PRE: state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (perm_done_i) state_d = LOAD;
            LOAD:    state_d = decrypt_q ? CHECK : OUT;
            OUT:     if (transfer && cnt_last) state_d = DONE;
            CHECK:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over everything, including a start seen in IDLE.
        if (abort_i) state_d = IDLE;
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            cnt_q     <= '0;
            decrypt_q <= 1'b0;
            auth_ok_q <= 1'b0;
        end else if (abort_i) begin
            cnt_q     <= '0;
            auth_ok_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (final_start_i) begin
                        decrypt_q <= decrypt_i;
                        auth_ok_q <= 1'b0;
                    end
                end
                OUT: begin
                    if (transfer) cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
                end
                CHECK:   auth_ok_q <= (tag_i == tag_ref_i);
                default: ;
            endcase
        end
    end

    assign xor_key_pre_o  = (state_q == KEY_PRE);
    assign perm_start_o   = (state_q == START);
    assign perm_rounds_o  = perm_start_o ? 4'(NB_ROUNDS) : 4'd0;
    assign xor_key_post_o = (state_q == LOAD);
    assign en_tag_o       = (state_q == LOAD);
    assign tag_valid_o    = (state_q == OUT);
    assign tag_word_o     = tag_valid_o ? tag_words[cnt_q] : '0;
    assign auth_ok_o      = auth_ok_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);

endmodule

// File: tb/tb_tag_ctrl.sv
// Directed bench for tag_ctrl: a cycle-by-cycle encrypt table, then
// hand-written sequences for backpressure, decrypt, abort, busy start and reset.
module tb_tag_ctrl;
    import ascon_pack::*;

    localparam int          WORD_W = 32;
    localparam logic [127:0] TAG   = 128'h0123456789ABCDEF_FEDCBA9876543210;

    logic              clock_i = 1'b0;
    logic              resetb_i = 1'b0;
    logic              final_start_i = 1'b0;
    logic              decrypt_i = 1'b0;
    logic              abort_i = 1'b0;
    logic              xor_key_pre_o;
    logic              perm_start_o;
    logic [3:0]        perm_rounds_o;
    logic              perm_done_i = 1'b0;
    logic              xor_key_post_o;
    logic              en_tag_o;
    logic [127:0]      tag_i = TAG;
    logic [127:0]      tag_ref_i = '0;
    logic [WORD_W-1:0] tag_word_o;
    logic              tag_valid_o;
    logic              tag_ready_i = 1'b0;
    logic              auth_ok_o;
    logic              busy_o;
    logic              done_o;

    tag_ctrl #(.WORD_W(WORD_W), .NB_ROUNDS(12)) dut (
        .clock_i        (clock_i),
        .resetb_i       (resetb_i),
        .final_start_i  (final_start_i),
        .decrypt_i      (decrypt_i),
        .abort_i        (abort_i),
        .xor_key_pre_o  (xor_key_pre_o),
        .perm_start_o   (perm_start_o),
        .perm_rounds_o  (perm_rounds_o),
        .perm_done_i    (perm_done_i),
        .xor_key_post_o (xor_key_post_o),
        .en_tag_o       (en_tag_o),
        .tag_i          (tag_i),
        .tag_ref_i      (tag_ref_i),
        .tag_word_o     (tag_word_o),
        .tag_valid_o    (tag_valid_o),
        .tag_ready_i    (tag_ready_i),
        .auth_ok_o      (auth_ok_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct packed {
        logic        key_pre;
        logic        pstart;
        logic [3:0]  rounds;
        logic        key_post;
        logic        en_tag;
        logic        valid;
        logic [31:0] word;
        logic        auth;
        logic        busy;
        logic        done;
    } exp_t;

    typedef struct {
        logic  start;
        logic  dec;
        logic  abort;
        logic  pdone;
        logic  ready;
        exp_t  exp;
        string name;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] tw [4];
    int          n_vec  = 0;
    int          n_miss = 0;

    function automatic exp_t ex_idle(input logic a);
        exp_t e = '0;
        e.auth = a;
        return e;
    endfunction

    function automatic exp_t ex_busy();
        exp_t e = '0;
        e.busy = 1'b1;
        return e;
    endfunction

    function automatic exp_t ex_keypre();
        exp_t e = ex_busy();
        e.key_pre = 1'b1;
        return e;
    endfunction

    function automatic exp_t ex_start();
        exp_t e = ex_busy();
        e.pstart = 1'b1;
        e.rounds = 4'd12;
        return e;
    endfunction

    function automatic exp_t ex_load();
        exp_t e = ex_busy();
        e.key_post = 1'b1;
        e.en_tag   = 1'b1;
        return e;
    endfunction

    function automatic exp_t ex_out(input logic [31:0] w);
        exp_t e = ex_busy();
        e.valid = 1'b1;
        e.word  = w;
        return e;
    endfunction

    function automatic exp_t ex_done(input logic a);
        exp_t e = ex_busy();
        e.done = 1'b1;
        e.auth = a;
        return e;
    endfunction

    function automatic void add(input logic s, input logic d, input logic ab,
                                input logic pd, input logic rd, input exp_t e,
                                input string nm);
        vec_t v;
        v.start = s; v.dec = d; v.abort = ab; v.pdone = pd; v.ready = rd;
        v.exp = e; v.name = nm;
        vq.push_back(v);
    endfunction

    task automatic check(input string nm, input exp_t e);
        exp_t got;
        got = {xor_key_pre_o, perm_start_o, perm_rounds_o, xor_key_post_o,
               en_tag_o, tag_valid_o, tag_word_o, auth_ok_o, busy_o, done_o};
        n_vec++;
        if (got !== e) begin
            n_miss++;
            $display("FAIL %s: got pre=%b ps=%b rnd=%0d post=%b en=%b v=%b w=%h ok=%b busy=%b done=%b, want pre=%b ps=%b rnd=%0d post=%b en=%b v=%b w=%h ok=%b busy=%b done=%b",
                     nm, got.key_pre, got.pstart, got.rounds, got.key_post, got.en_tag,
                     got.valid, got.word, got.auth, got.busy, got.done,
                     e.key_pre, e.pstart, e.rounds, e.key_post, e.en_tag,
                     e.valid, e.word, e.auth, e.busy, e.done);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and check the outputs of
    // the state the DUT is currently in; the following rising edge consumes them.
    task automatic step(input logic s, input logic d, input logic ab,
                        input logic pd, input logic rd, input exp_t e,
                        input string nm);
        @(negedge clock_i);
        final_start_i = s; decrypt_i = d; abort_i = ab;
        perm_done_i = pd; tag_ready_i = rd;
        #1;
        check(nm, e);
    endtask

    // Start through LOAD with the permutation finishing 12 cycles after its start pulse.
    task automatic prelude(input logic dec, input logic auth_before);
        step(1, dec, 0, 0, 0, ex_idle(auth_before), "idle_start");
        step(0, 0, 0, 0, 0, ex_keypre(), "key_pre");
        step(0, 0, 0, 0, 0, ex_start(), "perm_start");
        for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 0, ex_busy(), "wait");
        step(0, 0, 0, 1, 0, ex_busy(), "wait_done");
        step(0, 0, 0, 0, 0, ex_load(), "load");
    endtask

    initial begin
        tw = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};

        // Encrypt run as a cycle table; perm_done_i in IDLE at the end must be ignored.
        add(1, 0, 0, 0, 0, ex_idle(0), "t_idle_start");
        add(0, 0, 0, 0, 0, ex_keypre(), "t_key_pre");
        add(0, 0, 0, 0, 0, ex_start(), "t_perm_start");
        for (int i = 0; i < 11; i++) add(0, 0, 0, 0, 0, ex_busy(), "t_wait");
        add(0, 0, 0, 1, 0, ex_busy(), "t_wait_done");
        add(0, 0, 0, 0, 1, ex_load(), "t_load");
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, ex_out(tw[i]), "t_out");
        add(0, 0, 0, 0, 1, ex_done(0), "t_done");
        add(0, 0, 0, 1, 0, ex_idle(0), "t_idle_pdone");
        add(0, 0, 0, 0, 0, ex_idle(0), "t_idle_after");

        #12;
        check("reset", ex_idle(0));
        @(negedge clock_i);
        resetb_i = 1'b1;

        for (int i = 0; i < vq.size(); i++)
            step(vq[i].start, vq[i].dec, vq[i].abort, vq[i].pdone, vq[i].ready,
                 vq[i].exp, vq[i].name);

        // Backpressure: ready low for three cycles while word 1 is offered.
        prelude(0, 0);
        step(0, 0, 0, 0, 1, ex_out(tw[0]), "bp_w0");
        step(0, 0, 0, 0, 0, ex_out(tw[1]), "bp_hold1");
        step(0, 0, 0, 0, 0, ex_out(tw[1]), "bp_hold2");
        step(0, 0, 0, 0, 0, ex_out(tw[1]), "bp_hold3");
        step(0, 0, 0, 0, 1, ex_out(tw[1]), "bp_w1");
        step(0, 0, 0, 0, 1, ex_out(tw[2]), "bp_w2");
        step(0, 0, 0, 0, 1, ex_out(tw[3]), "bp_w3");
        step(0, 0, 0, 0, 1, ex_done(0), "bp_done");
        step(0, 0, 0, 0, 0, ex_idle(0), "bp_idle");

        // Decrypt, matching reference.
        tag_ref_i = TAG;
        prelude(1, 0);
        step(0, 0, 0, 0, 1, ex_busy(), "dec_check");
        step(0, 0, 0, 0, 0, ex_done(1), "dec_done_ok");
        step(0, 0, 0, 0, 0, ex_idle(1), "dec_hold_ok");

        // Decrypt, reference with bit 0 flipped; the start clears auth_ok_o.
        tag_ref_i = TAG ^ 128'h1;
        prelude(1, 1);
        step(0, 0, 0, 0, 1, ex_busy(), "bad_check");
        step(0, 0, 0, 0, 0, ex_done(0), "bad_done");
        step(0, 0, 0, 0, 0, ex_idle(0), "bad_idle");

        // Abort in WAIT together with perm_done_i.
        tag_ref_i = TAG;
        step(1, 1, 0, 0, 0, ex_idle(0), "ab_start");
        step(0, 0, 0, 0, 0, ex_keypre(), "ab_key_pre");
        step(0, 0, 0, 0, 0, ex_start(), "ab_perm_start");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, ex_busy(), "ab_wait");
        step(0, 0, 1, 1, 0, ex_busy(), "ab_wait_abort");
        step(0, 0, 0, 0, 0, ex_idle(0), "ab_idle1");
        step(0, 0, 0, 0, 0, ex_idle(0), "ab_idle2");

        // Abort in IDLE clears a held auth_ok_o and blocks a simultaneous start.
        prelude(1, 0);
        step(0, 0, 0, 0, 0, ex_busy(), "ab2_check");
        step(0, 0, 0, 0, 0, ex_done(1), "ab2_done");
        step(1, 1, 1, 0, 0, ex_idle(1), "ab2_abort_start");
        step(0, 0, 0, 0, 0, ex_idle(0), "ab2_cleared");

        // Start pulses while busy are ignored.
        prelude(0, 0);
        step(0, 0, 0, 0, 1, ex_out(tw[0]), "sb_w0");
        step(1, 0, 0, 0, 1, ex_out(tw[1]), "sb_w1_start");
        step(1, 1, 0, 0, 1, ex_out(tw[2]), "sb_w2_start");
        step(0, 0, 0, 0, 1, ex_out(tw[3]), "sb_w3");
        step(1, 0, 0, 0, 0, ex_done(0), "sb_done_start");
        step(0, 0, 0, 0, 0, ex_idle(0), "sb_idle1");
        step(0, 0, 0, 0, 0, ex_idle(0), "sb_idle2");

        // Asynchronous reset while word 2 is offered.
        prelude(0, 0);
        step(0, 0, 0, 0, 1, ex_out(tw[0]), "rs_w0");
        step(0, 0, 0, 0, 1, ex_out(tw[1]), "rs_w1");
        step(0, 0, 0, 0, 0, ex_out(tw[2]), "rs_w2");
        #2;
        resetb_i = 1'b0;
        #1;
        check("reset_async", ex_idle(0));
        @(negedge clock_i);
        resetb_i = 1'b1;
        prelude(0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, ex_out(tw[i]), "rs_rerun");
        step(0, 0, 0, 0, 1, ex_done(0), "rs_done");
        step(0, 0, 0, 0, 0, ex_idle(0), "rs_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
